// File: rtl/mac32_stim_gen.sv
// Operand generator and driver for the 32-bit FP MAC (Result = A + B*C): LFSR-built operands,
// valid/ready handoff, result capture. Optional macro MAC32_STIM_SPECIALS_EN forces A=+0, C=1.0.
module mac32_stim_gen #(
    parameter int unsigned PARM_XLEN   = 32,
    parameter int unsigned PARM_EXP    = 8,
    parameter int unsigned PARM_MANT   = 23,
    parameter int unsigned PARM_BIAS   = 127,
    parameter int unsigned NUM_TESTS   = 1000,
    parameter int unsigned LAT_TIMEOUT = 64,
    parameter logic [31:0] SEED        = 32'h1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    output logic [PARM_XLEN-1:0] A_o,
    output logic [PARM_XLEN-1:0] B_o,
    output logic [PARM_XLEN-1:0] C_o,
    output logic                 op_valid_o,
    input  logic                 op_ready_i,
    input  logic                 res_valid_i,
    input  logic [PARM_XLEN-1:0] Result_i,
    output logic [PARM_XLEN-1:0] Result_o,
    output logic                 result_ready_o,
    output logic                 sim_end_o,
    output logic                 busy_o,
    output logic [15:0]          tx_cnt_o,
    output logic                 timeout_err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StGen,
        StDrive,
        StWaitRes,
        StReport,
        StDone
    } state_e;

    // An all-zero seed would lock a Galois LFSR at zero forever.
    localparam logic [31:0] SeedRawA = SEED;
    localparam logic [31:0] SeedRawB = SEED ^ 32'h5A5A5A5A;
    localparam logic [31:0] SeedRawC = SEED ^ 32'hA5A5A5A5;
    localparam logic [31:0] SeedA    = (SeedRawA == 32'h0) ? 32'h1 : SeedRawA;
    localparam logic [31:0] SeedB    = (SeedRawB == 32'h0) ? 32'h1 : SeedRawB;
    localparam logic [31:0] SeedC    = (SeedRawC == 32'h0) ? 32'h1 : SeedRawC;

    localparam logic [PARM_EXP-1:0] ExpBase  = PARM_EXP'(PARM_BIAS - 16);
    localparam int unsigned         LatEff   = (LAT_TIMEOUT == 0) ? 1 : LAT_TIMEOUT;
    localparam logic [31:0]         LatLast  = 32'(LatEff - 1);
    localparam logic [15:0]         NumTests = 16'(NUM_TESTS);

`ifdef MAC32_STIM_SPECIALS_EN
    localparam logic [PARM_XLEN-1:0] FpOne = {1'b0, PARM_EXP'(PARM_BIAS), PARM_MANT'(0)};
`endif

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    // Exponent confined to bias-16 .. bias+15, so never zero/denormal/Inf/NaN.
    function automatic logic [PARM_XLEN-1:0] to_operand(input logic sgn,
                                                        input logic [4:0] exp_off,
                                                        input logic [PARM_MANT-1:0] mant);
        logic [PARM_EXP-1:0] exp_f;
        exp_f = ExpBase + PARM_EXP'(exp_off);
        return {sgn, exp_f, mant};
    endfunction

    state_e                 state_q, state_d;
    logic [31:0]            la_q, la_d;
    logic [31:0]            lb_q, lb_d;
    logic [31:0]            lc_q, lc_d;
    logic [PARM_XLEN-1:0]   a_q, a_d;
    logic [PARM_XLEN-1:0]   b_q, b_d;
    logic [PARM_XLEN-1:0]   c_q, c_d;
    logic [PARM_XLEN-1:0]   result_q, result_d;
    logic [15:0]            tx_cnt_q, tx_cnt_d;
    logic [31:0]            wait_cnt_q, wait_cnt_d;
    logic                   timeout_err_q, timeout_err_d;

    always_comb begin
        state_d       = state_q;
        la_d          = la_q;
        lb_d          = lb_q;
        lc_d          = lc_q;
        a_d           = a_q;
        b_d           = b_q;
        c_d           = c_q;
        result_d      = result_q;
        tx_cnt_d      = tx_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    tx_cnt_d      = 16'h0;
                    timeout_err_d = 1'b0;
                    state_d       = (NumTests == 16'h0) ? StDone : StGen;
                end
            end
            StGen: begin
                la_d    = lfsr_next(la_q);
                lb_d    = lfsr_next(lb_q);
                lc_d    = lfsr_next(lc_q);
                a_d     = to_operand(la_d[31], la_d[4:0], la_d[PARM_MANT-1:0]);
                b_d     = to_operand(lb_d[31], lb_d[4:0], lb_d[PARM_MANT-1:0]);
                c_d     = to_operand(lc_d[31], lc_d[4:0], lc_d[PARM_MANT-1:0]);
`ifdef MAC32_STIM_SPECIALS_EN
                // Every 16th transaction: 0 + B*1.0 must return B bit-exact.
                if (tx_cnt_q[3:0] == 4'hF) begin
                    a_d = '0;
                    c_d = FpOne;
                end
`endif
                state_d = StDrive;
            end
            StDrive: begin
                if (op_ready_i) begin
                    wait_cnt_d = 32'h0;
                    state_d    = StWaitRes;
                end
            end
            StWaitRes: begin
                // A result arriving on the expiry cycle takes priority over the timeout.
                if (res_valid_i) begin
                    result_d = Result_i;
                    state_d  = StReport;
                end else if (wait_cnt_q == LatLast) begin
                    timeout_err_d = 1'b1;
                    state_d       = StDone;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'h1;
                end
            end
            StReport: begin
                tx_cnt_d = tx_cnt_q + 16'h1;
                state_d  = (tx_cnt_d == NumTests) ? StDone : StGen;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            la_q          <= SeedA;
            lb_q          <= SeedB;
            lc_q          <= SeedC;
            a_q           <= '0;
            b_q           <= '0;
            c_q           <= '0;
            result_q      <= '0;
            tx_cnt_q      <= 16'h0;
            wait_cnt_q    <= 32'h0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            la_q          <= la_d;
            lb_q          <= lb_d;
            lc_q          <= lc_d;
            a_q           <= a_d;
            b_q           <= b_d;
            c_q           <= c_d;
            result_q      <= result_d;
            tx_cnt_q      <= tx_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign A_o            = a_q;
    assign B_o            = b_q;
    assign C_o            = c_q;
    assign Result_o       = result_q;
    assign tx_cnt_o       = tx_cnt_q;
    assign timeout_err_o  = timeout_err_q;
    assign op_valid_o     = (state_q == StDrive);
    assign result_ready_o = (state_q == StReport);
    assign sim_end_o      = (state_q == StDone);
    assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_mac32_stim_gen.sv
// Randomized self-checking bench for mac32_stim_gen against a transaction-level operand model.
module tb_mac32_stim_gen;

    localparam int          NUM  = 18;
    localparam int          LAT  = 8;
    localparam logic [31:0] SEED = 32'h1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        op_ready_i = 1'b0;
    logic        res_valid_i = 1'b0;
    logic [31:0] Result_i = 32'h0;
    logic [31:0] A_o, B_o, C_o, Result_o;
    logic        op_valid_o, result_ready_o, sim_end_o, busy_o, timeout_err_o;
    logic [15:0] tx_cnt_o;

    mac32_stim_gen #(
        .NUM_TESTS  (NUM),
        .LAT_TIMEOUT(LAT),
        .SEED       (SEED)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .A_o           (A_o),
        .B_o           (B_o),
        .C_o           (C_o),
        .op_valid_o    (op_valid_o),
        .op_ready_i    (op_ready_i),
        .res_valid_i   (res_valid_i),
        .Result_i      (Result_i),
        .Result_o      (Result_o),
        .result_ready_o(result_ready_o),
        .sim_end_o     (sim_end_o),
        .busy_o        (busy_o),
        .tx_cnt_o      (tx_cnt_o),
        .timeout_err_o (timeout_err_o)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    int unsigned prev_pulse = 0;
    int unsigned pulse_gap = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [31:0] m_la, m_lb, m_lc, m_a, m_b, m_c, m_res;
    int          m_cnt;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic logic [31:0] to_float(input logic [31:0] r);
        int unsigned e;
        e = 127 - 16 + r[4:0];
        return {r[31], e[7:0], r[22:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_la  = SEED;
        m_lb  = SEED ^ 32'h5A5A5A5A;
        m_lc  = SEED ^ 32'hA5A5A5A5;
        m_res = 32'h0;
        m_cnt = 0;
    endtask

    task automatic model_gen();
        m_la = lfsr_step(m_la);
        m_lb = lfsr_step(m_lb);
        m_lc = lfsr_step(m_lc);
        m_a  = to_float(m_la);
        m_b  = to_float(m_lb);
        m_c  = to_float(m_lc);
`ifdef MAC32_STIM_SPECIALS_EN
        if (m_cnt % 16 == 15) begin
            m_a = 32'h0;
            m_c = 32'h3F800000;
        end
`endif
    endtask

    // Runs one transaction from the wait for op_valid_o through report/timeout.
    task automatic txn(input int rdy_wait, input int res_wait, input logic [31:0] res_val,
                       input bit expect_tmo);
        int guard = 0;
        while (op_valid_o !== 1'b1 && guard < 10) begin
            tick();
            guard++;
        end
        n_vec++;
        if (op_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL op_valid_wait: op_valid=%b required 1", op_valid_o);
            return;
        end
        model_gen();
        n_vec++;
        if ({A_o, B_o, C_o} !== {m_a, m_b, m_c}) begin
            n_err++;
            $display("FAIL operands tx%0d: got %h %h %h required %h %h %h", m_cnt, A_o, B_o,
                     C_o, m_a, m_b, m_c);
        end
        n_vec++;
        if ({tx_cnt_o, Result_o} !== {16'(m_cnt), m_res}) begin
            n_err++;
            $display("FAIL held_state: tx_cnt=%0d Result=%h required %0d %h", tx_cnt_o,
                     Result_o, m_cnt, m_res);
        end
        // Stall: stray result/start pulses here must be ignored.
        for (int i = 0; i < rdy_wait; i++) begin
            op_ready_i  = 1'b0;
            res_valid_i = 1'($urandom_range(0, 1));
            Result_i    = $urandom;
            start_i     = 1'($urandom_range(0, 1));
            tick();
            n_vec++;
            if ({op_valid_o, A_o, B_o, C_o} !== {1'b1, m_a, m_b, m_c}) begin
                n_err++;
                $display("FAIL stall_hold: valid=%b ops %h %h %h required 1 %h %h %h",
                         op_valid_o, A_o, B_o, C_o, m_a, m_b, m_c);
            end
        end
        start_i     = 1'b0;
        res_valid_i = 1'b0;
        op_ready_i  = 1'b1;
        tick();
        op_ready_i = 1'b0;
        n_vec++;
        if (op_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL valid_drop: op_valid=%b required 0", op_valid_o);
        end
        if (expect_tmo) begin
            for (int i = 0; i < LAT - 1; i++) begin
                op_ready_i = 1'($urandom_range(0, 1));
                tick();
            end
            op_ready_i = 1'b0;
            n_vec++;
            if ({timeout_err_o, sim_end_o, busy_o} !== 3'b001) begin
                n_err++;
                $display("FAIL early_timeout: err/end/busy=%b required 001",
                         {timeout_err_o, sim_end_o, busy_o});
            end
            tick();
            n_vec++;
            if ({timeout_err_o, sim_end_o, result_ready_o} !== 3'b110) begin
                n_err++;
                $display("FAIL timeout: err/end/rdy=%b required 110",
                         {timeout_err_o, sim_end_o, result_ready_o});
            end
            tick();
            n_vec++;
            if ({busy_o, sim_end_o, timeout_err_o, tx_cnt_o} !== {3'b001, 16'(m_cnt)}) begin
                n_err++;
                $display("FAIL timeout_end: busy/end/err=%b tx_cnt=%0d required 001 %0d",
                         {busy_o, sim_end_o, timeout_err_o}, tx_cnt_o, m_cnt);
            end
            return;
        end
        for (int i = 0; i < res_wait; i++) tick();
        res_valid_i = 1'b1;
        Result_i    = res_val;
        tick();
        res_valid_i = 1'b0;
        Result_i    = $urandom;
        m_res       = res_val;
        pulse_gap   = cyc - prev_pulse;
        prev_pulse  = cyc;
        n_vec++;
        if ({result_ready_o, timeout_err_o, Result_o} !== {2'b10, m_res}) begin
            n_err++;
            $display("FAIL report: rdy/err=%b Result=%h required 10 %h",
                     {result_ready_o, timeout_err_o}, Result_o, m_res);
        end
        tick();
        m_cnt++;
        n_vec++;
        if ({result_ready_o, tx_cnt_o} !== {1'b0, 16'(m_cnt)}) begin
            n_err++;
            $display("FAIL count: rdy=%b tx_cnt=%0d required 0 %0d", result_ready_o,
                     tx_cnt_o, m_cnt);
        end
        if (m_cnt == NUM) begin
            n_vec++;
            if (sim_end_o !== 1'b1) begin
                n_err++;
                $display("FAIL sim_end: got %b required 1", sim_end_o);
            end
            tick();
            n_vec++;
            if ({busy_o, sim_end_o} !== 2'b00) begin
                n_err++;
                $display("FAIL run_end: busy/end=%b required 00", {busy_o, sim_end_o});
            end
        end else begin
            n_vec++;
            if ({busy_o, sim_end_o} !== 2'b10) begin
                n_err++;
                $display("FAIL mid_run: busy/end=%b required 10", {busy_o, sim_end_o});
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start_i = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({A_o, B_o, C_o, Result_o, op_valid_o, result_ready_o, sim_end_o, busy_o, tx_cnt_o,
             timeout_err_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: A=%h B=%h C=%h R=%h busy=%b tx=%0d required all 0",
                     A_o, B_o, C_o, Result_o, busy_o, tx_cnt_o);
        end
        rst_n   = 1'b1;
        start_i = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_back_to_back();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_vec++;
        if ({busy_o, op_valid_o} !== 2'b10) begin
            n_err++;
            $display("FAIL start_gen: busy/valid=%b required 10", {busy_o, op_valid_o});
        end
        tick();
        n_vec++;
        if ({op_valid_o, A_o} !== {1'b1, 32'hB9200003}) begin
            n_err++;
            $display("FAIL first_op: valid=%b A=%h required 1 b9200003", op_valid_o, A_o);
        end
        for (int t = 0; t < 4; t++) begin
            op_ready_i = 1'b1;
            txn(0, 0, 32'h3F800000, 1'b0);
            if (t > 0) begin
                n_vec++;
                if (pulse_gap != 4) begin
                    n_err++;
                    $display("FAIL pulse_gap: got %0d cycles required 4", pulse_gap);
                end
            end
        end
    endtask

    task automatic test_stall();
        txn(10, 0, $urandom, 1'b0);
    endtask

    task automatic test_random();
        while (m_cnt < NUM) begin
            int rw;
            int sw;
            rw = $urandom_range(0, 3);
            sw = (m_cnt == 8) ? LAT - 1 : $urandom_range(0, 3);
            txn(rw, sw, $urandom, 1'b0);
        end
    endtask

    task automatic test_idle_hold();
        for (int i = 0; i < 5; i++) begin
            res_valid_i = 1'($urandom_range(0, 1));
            op_ready_i  = 1'($urandom_range(0, 1));
            Result_i    = $urandom;
            tick();
            n_vec++;
            if ({busy_o, op_valid_o, tx_cnt_o, Result_o} !== {2'b00, 16'(NUM), m_res}) begin
                n_err++;
                $display("FAIL idle_hold: busy/valid=%b tx=%0d R=%h required 00 %0d %h",
                         {busy_o, op_valid_o}, tx_cnt_o, Result_o, NUM, m_res);
            end
        end
        res_valid_i = 1'b0;
        op_ready_i  = 1'b0;
    endtask

    task automatic test_timeout();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        m_cnt   = 0;
        txn(0, 0, 32'h0, 1'b1);
    endtask

    task automatic test_reset_midrun();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        m_cnt   = 0;
        n_vec++;
        if ({timeout_err_o, tx_cnt_o} !== 17'h0) begin
            n_err++;
            $display("FAIL start_clear: err=%b tx=%0d required 0 0", timeout_err_o, tx_cnt_o);
        end
        tick();
        model_gen();
        op_ready_i = 1'b1;
        tick();
        op_ready_i = 1'b0;
        tick();
        rst_n       = 1'b0;
        res_valid_i = 1'b1;
        Result_i    = 32'hDEADBEEF;
        tick();
        rst_n       = 1'b1;
        res_valid_i = 1'b0;
        model_reset();
        n_vec++;
        if ({A_o, B_o, C_o, Result_o, op_valid_o, result_ready_o, sim_end_o, busy_o, tx_cnt_o,
             timeout_err_o} !== '0) begin
            n_err++;
            $display("FAIL midrun_reset: A=%h R=%h busy=%b rdy=%b required all 0", A_o,
                     Result_o, busy_o, result_ready_o);
        end
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        model_gen();
        n_vec++;
        if ({op_valid_o, A_o, B_o, C_o} !== {1'b1, 32'hB9200003, m_b, m_c}) begin
            n_err++;
            $display("FAIL reseed: valid=%b ops %h %h %h required 1 b9200003 %h %h",
                     op_valid_o, A_o, B_o, C_o, m_b, m_c);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_back_to_back();
        test_stall();
        test_random();
        test_idle_hold();
        test_timeout();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mac32_stim_gen.md
Name: mac32_stim_gen

Overview:
Synthesizable operand generator and driver for the 32-bit floating-point MAC unit (Result = A + B*C). It produces pseudo-random, range-constrained IEEE-754 single-precision operand triples and presents them to the DUT over a valid/ready handshake. It then waits for the DUT result and hands the completed transaction to the checking side as a one-cycle result_ready pulse. It is the transmitting end of the mac32 transaction stream; the scoreboard consumes what this block emits, and sim_end_o marks the end of the run.

Parameters:
- PARM_XLEN, 32: operand/result width.
- PARM_EXP, 8: exponent field width.
- PARM_MANT, 23: mantissa field width.
- PARM_BIAS, 127: exponent bias.
- NUM_TESTS, 1000: transactions per run (16-bit range).
- LAT_TIMEOUT, 64: maximum cycles from operand handshake to res_valid_i.
- SEED, 32'h1: LFSR seed base.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start_i  in  1  starts a run; sampled only in IDLE.
- A_o, B_o, C_o  out  32 each  operands, held stable from DRIVE through REPORT.
- op_valid_o  out  1  operands valid.
- op_ready_i  in  1  DUT accepts operands.
- res_valid_i  in  1  DUT result valid.
- Result_i  in  32  DUT result.
- Result_o  out  32  captured result, held until the next capture.
- result_ready_o  out  1  one-cycle pulse: A_o/B_o/C_o/Result_o form a complete transaction.
- sim_end_o  out  1  one-cycle end-of-run pulse.
- busy_o  out  1  high in any state other than IDLE.
- tx_cnt_o  out  16  completed transactions in the current run.
- timeout_err_o  out  1  sticky; cleared by reset or start_i.

Behaviour:
- Reset (synchronous, rst_n=0 at a clk edge):
  - All outputs go to 0 and the state goes to IDLE.
  - LFSRs load LA=SEED, LB=SEED^32'h5A5A5A5A, LC=SEED^32'hA5A5A5A5. Any seed that evaluates to 0 is replaced by 32'h1.
  - Reset wins over every other event, including in mid-transaction.
- LFSR (Galois): next = {1'b0,s[31:1]} ^ (s[0] ? 32'h80200003 : 0). All three LFSRs advance once per GEN cycle.
- Operand mapping from an advanced LFSR value r:
  - sign = r[31].
  - exp = PARM_BIAS-16+r[4:0], giving the range 111..142.
  - mant = r[22:0].
  - Result: never zero, denormal, Inf or NaN.
- State machine:
  - IDLE: on start_i, clear tx_cnt_o and timeout_err_o. If NUM_TESTS==0, go to DONE; otherwise go to GEN.
  - GEN (1 cycle): advance the LFSRs and register A_o/B_o/C_o, then go to DRIVE.
  - DRIVE: op_valid_o=1 with operands stable. When op_valid_o&&op_ready_i, drop op_valid_o on the next cycle, clear the timeout counter and go to WAIT_RES. op_ready_i outside DRIVE is ignored.
  - WAIT_RES: count cycles.
    - res_valid_i=1: register Result_i into Result_o and go to REPORT.
    - Counter reaches LAT_TIMEOUT with no result: set timeout_err_o and go to DONE.
    - res_valid_i in the same cycle the counter expires: the result wins and no error is raised.
    - res_valid_i outside WAIT_RES is ignored.
  - REPORT (1 cycle): result_ready_o=1 and tx_cnt_o increments. Go to DONE if the new count equals NUM_TESTS, otherwise go to GEN.
  - DONE (1 cycle): sim_end_o=1, then go to IDLE.
- Latency: start_i to the first op_valid_o is 2 cycles. Minimum transaction period is 4 cycles (GEN, DRIVE, WAIT_RES, REPORT) with zero-wait ready and result.
- start_i while busy_o=1 is ignored.
- tx_cnt_o holds its final value in IDLE until the next start_i.

Optional Feature:
MAC32_STIM_SPECIALS_EN:
- Defined: on transactions with tx_cnt_o[3:0]==4'hF, GEN overrides A_o=32'h00000000 (+0.0) and C_o=32'h3F800000 (1.0), so the expected result equals B_o exactly. The LFSRs still advance normally.
- Undefined: every operand comes from the LFSR mapping only.

Test Plan:
1. SEED=1, start_i, op_ready_i=1 -> first A_o=32'hB9200003 (LA advanced to 32'h80200003); op_valid_o rises 2 cycles after start_i.
2. NUM_TESTS=4, zero-wait ready, res_valid_i one cycle after handshake with Result_i=32'h3F800000 -> four result_ready_o pulses 4 cycles apart; Result_o=32'h3F800000; tx_cnt_o=4; one sim_end_o pulse; busy_o low afterwards.
3. op_ready_i held low for 10 cycles -> op_valid_o stays high and A_o/B_o/C_o are unchanged for all 10 cycles; handshake completes on the cycle op_ready_i rises.
4. LAT_TIMEOUT=8, res_valid_i never asserted -> timeout_err_o=1 at cycle 8 of WAIT_RES; sim_end_o pulses; tx_cnt_o=0; no result_ready_o.
5. rst_n low for one cycle in WAIT_RES -> next cycle busy_o=0, all outputs 0; a later start_i with the same SEED reproduces the scenario-1 A_o.
6. Macro defined, NUM_TESTS=16 -> the 16th transaction has A_o=32'h0 and C_o=32'h3F800000; the other 15 are unaffected.
